ysyx_23060025_axi_rd_arbiter: RTL and testbench

- Shares one AXI4 read channel (AR + R) to the DRAM/crossbar between two read masters.
- Master 0 is the icache line-fill port. Master 1 is the LSU read port.
- Grants whole transactions: a granted master keeps the channel from its AR handshake until its R beat with rlast.
- Arbitration is round-robin. It counts burst beats and flags protocol errors.

---
 rtl/ysyx_23060025_axi_rd_arbiter_pkg.sv | 28 ++
 rtl/ysyx_23060025_rr_sel2.sv | 19 +
 rtl/ysyx_23060025_axi_rd_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ysyx_23060025_axi_rd_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060025_axi_rd_arbiter_pkg.sv
// Shared encodings for the two-master AXI read arbiter: FSM states, master IDs,
// AXI size/burst constants and the beat-counter helper.
package ysyx_23060025_axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        AR   = 2'b01,
        R    = 2'b10
    } arb_state_e;

    localparam logic ICACHE = 1'b0;
    localparam logic LSU    = 1'b1;

    localparam logic [2:0] AXI_SIZE_1B = 3'b000;
    localparam logic [2:0] AXI_SIZE_2B = 3'b001;
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;
    localparam logic [2:0] AXI_SIZE_8B = 3'b011;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    // Saturates at zero so a late rlast keeps being reported instead of wrapping.
    function automatic logic [7:0] beat_dec(input logic [7:0] cnt);
        return (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
    endfunction

endpackage

// File: rtl/ysyx_23060025_rr_sel2.sv
// Two-way request picker: round-robin on ties when rr_en=1, otherwise the LSU
// (master 1) wins ties. A lone requester always wins.
module ysyx_23060025_rr_sel2
    import ysyx_23060025_axi_rd_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       lg,
    input  logic       rr_en,
    output logic       grant
);

    always_comb begin
        grant = req[1];
        if (req == 2'b11) begin
            grant = rr_en ? ~lg : LSU;
        end
    end

endmodule

// File: rtl/ysyx_23060025_axi_rd_arbiter.sv
// Shares one AXI4 read channel between the icache (master 0) and the LSU
// (master 1), granting whole transactions from AR handshake through rlast.
module ysyx_23060025_axi_rd_arbiter
    import ysyx_23060025_axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter bit RR_EN      = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    input  logic [7:0]            m0_arlen,
    input  logic [2:0]            m0_arsize,
    input  logic [1:0]            m0_arburst,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rlast,

    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    input  logic [7:0]            m1_arlen,
    input  logic [2:0]            m1_arsize,
    input  logic [1:0]            m1_arburst,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rlast,

    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [7:0]            s_arlen,
    output logic [2:0]            s_arsize,
    output logic [1:0]            s_arburst,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rlast,

    output logic                  grant_id,
    output logic                  busy,
    output logic                  proto_err
);

    arb_state_e state_q, state_d;
    logic       grant_id_q;
    logic       lg_q;
    logic [7:0] beat_cnt_q;
    logic       proto_err_q;
    logic       grant_sel;
    logic       ar_hs;
    logic       r_hs;

    ysyx_23060025_rr_sel2 u_sel (
        .req   ({m1_arvalid, m0_arvalid}),
        .lg    (lg_q),
        .rr_en (RR_EN),
        .grant (grant_sel)
    );

    assign ar_hs = (state_q == AR) && s_arvalid && s_arready;
    assign r_hs  = (state_q == R) && s_rvalid && s_rready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_id_q  <= ICACHE;
            lg_q        <= LSU;
            beat_cnt_q  <= 8'd0;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (m0_arvalid || m1_arvalid)) begin
                grant_id_q <= grant_sel;
            end
            if (ar_hs) begin
                beat_cnt_q <= s_arlen;
                lg_q       <= grant_id_q;
            end
            if (r_hs) begin
                beat_cnt_q <= beat_dec(beat_cnt_q);
                // rlast must coincide exactly with the final counted beat.
                if (s_rlast != (beat_cnt_q == 8'd0)) begin
                    proto_err_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (m0_arvalid || m1_arvalid) state_d = AR;
            AR:      if (ar_hs) state_d = R;
            R:       if (r_hs && s_rlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_arlen    = 8'd0;
        s_arsize   = 3'd0;
        s_arburst  = 2'd0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'd0;
        m0_rlast   = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'd0;
        m1_rlast   = 1'b0;
        case (state_q)
            AR: begin
                if (grant_id_q == LSU) begin
                    s_araddr   = m1_araddr;
                    s_arvalid  = m1_arvalid;
                    s_arlen    = m1_arlen;
                    s_arsize   = m1_arsize;
                    s_arburst  = m1_arburst;
                    m1_arready = s_arready;
                end else begin
                    s_araddr   = m0_araddr;
                    s_arvalid  = m0_arvalid;
                    s_arlen    = m0_arlen;
                    s_arsize   = m0_arsize;
                    s_arburst  = m0_arburst;
                    m0_arready = s_arready;
                end
            end
            R: begin
                if (grant_id_q == LSU) begin
                    s_rready  = m1_rready;
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rlast  = s_rlast;
                end else begin
                    s_rready  = m0_rready;
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rlast  = s_rlast;
                end
            end
            default: ;
        endcase
    end

    assign grant_id  = grant_id_q;
    assign busy      = (state_q != IDLE);
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ysyx_23060025_axi_rd_arbiter.sv
// Directed bench for the two-master AXI read arbiter; a second instance with
// RR_EN=0 shares the stimulus for the fixed-priority case.
module tb_ysyx_23060025_axi_rd_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] m0_araddr, m1_araddr;
    logic        m0_arvalid, m1_arvalid;
    logic [7:0]  m0_arlen, m1_arlen;
    logic [2:0]  m0_arsize, m1_arsize;
    logic [1:0]  m0_arburst, m1_arburst;
    logic        m0_rready, m1_rready;
    logic        s_arready, s_rvalid, s_rlast;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;

    logic        m0_arready, m0_rvalid, m0_rlast, m1_arready, m1_rvalid, m1_rlast;
    logic [31:0] m0_rdata, m1_rdata, s_araddr;
    logic [1:0]  m0_rresp, m1_rresp, s_arburst;
    logic        s_arvalid, s_rready, grant_id, busy, proto_err;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;

    logic        fp_m0_arready, fp_m0_rvalid, fp_m0_rlast, fp_m1_arready, fp_m1_rvalid, fp_m1_rlast;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_araddr;
    logic [1:0]  fp_m0_rresp, fp_m1_rresp, fp_s_arburst;
    logic        fp_s_arvalid, fp_s_rready, fp_grant_id, fp_busy, fp_proto_err;
    logic [7:0]  fp_s_arlen;
    logic [2:0]  fp_s_arsize;

    int errors = 0;
    int checks = 0;

    ysyx_23060025_axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_EN(1'b1)) dut (
        .clock(clock), .reset(reset),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .grant_id(grant_id), .busy(busy), .proto_err(proto_err)
    );

    ysyx_23060025_axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_EN(1'b0)) dut_fp (
        .clock(clock), .reset(reset),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(fp_m0_arready),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_rvalid(fp_m0_rvalid), .m0_rready(m0_rready), .m0_rdata(fp_m0_rdata),
        .m0_rresp(fp_m0_rresp), .m0_rlast(fp_m0_rlast),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(fp_m1_arready),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_rvalid(fp_m1_rvalid), .m1_rready(m1_rready), .m1_rdata(fp_m1_rdata),
        .m1_rresp(fp_m1_rresp), .m1_rlast(fp_m1_rlast),
        .s_araddr(fp_s_araddr), .s_arvalid(fp_s_arvalid), .s_arready(s_arready),
        .s_arlen(fp_s_arlen), .s_arsize(fp_s_arsize), .s_arburst(fp_s_arburst),
        .s_rvalid(s_rvalid), .s_rready(fp_s_rready), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .grant_id(fp_grant_id), .busy(fp_busy), .proto_err(fp_proto_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic zero_inputs();
        m0_araddr = '0; m0_arvalid = 0; m0_arlen = '0; m0_arsize = 3'd2; m0_arburst = 2'b01; m0_rready = 0;
        m1_araddr = '0; m1_arvalid = 0; m1_arlen = '0; m1_arsize = 3'd2; m1_arburst = 2'b01; m1_rready = 0;
        s_arready = 0; s_rvalid = 0; s_rlast = 0; s_rdata = '0; s_rresp = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        zero_inputs();
        step();
        reset = 1'b1;
    endtask

    // Checks the AR-phase routing for the expected owner.
    task automatic ar_check(input logic id, input logic [31:0] addr, input logic [7:0] len);
        chk("ar_grant", 32'(grant_id), 32'(id));
        chk("ar_busy", 32'(busy), 32'd1);
        chk("ar_s_arvalid", 32'(s_arvalid), 32'd1);
        chk("ar_s_araddr", s_araddr, addr);
        chk("ar_s_arlen", 32'(s_arlen), 32'(len));
        chk("ar_owner_arready", 32'(id ? m1_arready : m0_arready), 32'(s_arready));
        chk("ar_other_arready", 32'(id ? m0_arready : m1_arready), 32'd0);
    endtask

    // Presents one slave beat, checks it is routed only to the owner, then consumes it.
    task automatic do_beat(input logic id, input logic [31:0] d, input logic last, input logic [1:0] resp);
        s_rvalid = 1; s_rdata = d; s_rlast = last; s_rresp = resp;
        #1;
        chk("beat_rvalid", 32'(id ? m1_rvalid : m0_rvalid), 32'd1);
        chk("beat_rdata", id ? m1_rdata : m0_rdata, d);
        chk("beat_rlast", 32'(id ? m1_rlast : m0_rlast), 32'(last));
        chk("beat_rresp", 32'(id ? m1_rresp : m0_rresp), 32'(resp));
        chk("beat_other_rvalid", 32'(id ? m0_rvalid : m1_rvalid), 32'd0);
        chk("beat_s_rready", 32'(s_rready), 32'd1);
        step();
        s_rvalid = 0; s_rlast = 0; s_rdata = '0; s_rresp = '0;
    endtask

    initial begin
        zero_inputs();
        reset = 1'b0;
        m0_arvalid = 1; m1_arvalid = 1; s_arready = 1; s_rvalid = 1;
        step(); step(); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_s_arvalid", 32'(s_arvalid), 32'd0);
        chk("rst_m0_arready", 32'(m0_arready), 32'd0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_s_rready", 32'(s_rready), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);

        // Single icache burst of 4 beats.
        do_reset();
        m0_araddr = 32'h8000_0010; m0_arlen = 8'd3; m0_arvalid = 1; s_arready = 1; m0_rready = 1;
        #1;
        chk("t1_idle_no_fwd", 32'(s_arvalid), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        step(); #1;
        ar_check(1'b0, 32'h8000_0010, 8'd3);
        step();
        m0_arvalid = 0;
        #1;
        chk("t1_r_busy", 32'(busy), 32'd1);
        chk("t1_r_no_arvalid", 32'(s_arvalid), 32'd0);
        for (int i = 0; i < 4; i++) do_beat(1'b0, 32'hA0 + 32'(i), i == 3, 2'b00);
        #1;
        chk("t1_done_busy", 32'(busy), 32'd0);
        chk("t1_done_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("t1_done_proto_err", 32'(proto_err), 32'd0);

        // Round-robin tie right after reset: icache first, LSU next, icache again.
        do_reset();
        m0_araddr = 32'h0000_1000; m0_arlen = 8'd0; m0_arvalid = 1;
        m1_araddr = 32'h0000_2000; m1_arlen = 8'd0; m1_arvalid = 1;
        s_arready = 1; m0_rready = 1; m1_rready = 1;
        step(); #1;
        ar_check(1'b0, 32'h0000_1000, 8'd0);
        step();
        m0_arvalid = 0;
        do_beat(1'b0, 32'h55, 1'b1, 2'b00);
        #1;
        chk("t2_gap_busy", 32'(busy), 32'd0);
        chk("t2_gap_m1_arready", 32'(m1_arready), 32'd0);
        step(); #1;
        ar_check(1'b1, 32'h0000_2000, 8'd0);
        step();
        m1_arvalid = 0;
        do_beat(1'b1, 32'h66, 1'b1, 2'b01);
        m0_arvalid = 1; m1_arvalid = 1;
        step(); #1;
        ar_check(1'b0, 32'h0000_1000, 8'd0);

        // Fixed priority instance: LSU wins the tie, icache follows.
        do_reset();
        m0_araddr = 32'h0000_3000; m0_arlen = 8'd1; m0_arvalid = 1;
        m1_araddr = 32'h0000_4000; m1_arlen = 8'd0; m1_arvalid = 1;
        s_arready = 1; m0_rready = 1; m1_rready = 1;
        step(); #1;
        chk("t3_fp_grant", 32'(fp_grant_id), 32'd1);
        chk("t3_fp_s_araddr", fp_s_araddr, 32'h0000_4000);
        chk("t3_fp_m1_arready", 32'(fp_m1_arready), 32'd1);
        chk("t3_fp_m0_arready", 32'(fp_m0_arready), 32'd0);
        step();
        m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'h99; s_rlast = 1;
        #1;
        chk("t3_fp_m1_rvalid", 32'(fp_m1_rvalid), 32'd1);
        chk("t3_fp_m1_rdata", fp_m1_rdata, 32'h99);
        chk("t3_fp_m0_rvalid", 32'(fp_m0_rvalid), 32'd0);
        step();
        s_rvalid = 0; s_rlast = 0; s_rdata = '0;
        #1;
        chk("t3_fp_gap_busy", 32'(fp_busy), 32'd0);
        step(); #1;
        chk("t3_fp_grant2", 32'(fp_grant_id), 32'd0);
        chk("t3_fp_s_araddr2", fp_s_araddr, 32'h0000_3000);
        chk("t3_fp_s_arlen2", 32'(fp_s_arlen), 32'd1);

        // Slave backpressure on AR and gaps between R beats.
        do_reset();
        m0_araddr = 32'h0000_5000; m0_arlen = 8'd3; m0_arvalid = 1; s_arready = 0; m0_rready = 1;
        step(); #1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_ar_hold_valid", 32'(s_arvalid), 32'd1);
            chk("t4_ar_hold_ready", 32'(m0_arready), 32'd0);
            chk("t4_ar_hold_busy", 32'(busy), 32'd1);
            step(); #1;
        end
        s_arready = 1;
        #1;
        chk("t4_ar_ready", 32'(m0_arready), 32'd1);
        step();
        m0_arvalid = 0; s_arready = 0;
        for (int i = 0; i < 4; i++) begin
            do_beat(1'b0, 32'h11 * 32'(i + 1), i == 3, 2'b00);
            #1;
            if (i < 3) begin
                chk("t4_gap_rvalid", 32'(m0_rvalid), 32'd0);
                chk("t4_gap_busy", 32'(busy), 32'd1);
                step();
            end
        end
        chk("t4_done_busy", 32'(busy), 32'd0);

        // Early rlast: arlen=3 but rlast arrives on beat 2.
        do_reset();
        m0_araddr = 32'h0000_6000; m0_arlen = 8'd3; m0_arvalid = 1; s_arready = 1; m0_rready = 1;
        step(); step();
        m0_arvalid = 0;
        do_beat(1'b0, 32'h1, 1'b0, 2'b00);
        #1;
        chk("t5_err_before", 32'(proto_err), 32'd0);
        do_beat(1'b0, 32'h2, 1'b1, 2'b10);
        #1;
        chk("t5_err_set", 32'(proto_err), 32'd1);
        chk("t5_idle", 32'(busy), 32'd0);
        m1_araddr = 32'h0000_7000; m1_arlen = 8'd0; m1_arvalid = 1; m1_rready = 1;
        step(); #1;
        ar_check(1'b1, 32'h0000_7000, 8'd0);
        step();
        m1_arvalid = 0;
        do_beat(1'b1, 32'h3, 1'b1, 2'b00);
        #1;
        chk("t5_next_done", 32'(busy), 32'd0);
        chk("t5_err_sticky", 32'(proto_err), 32'd1);

        // Asynchronous reset between beat 1 and beat 2.
        m1_araddr = 32'h0000_7100; m1_arlen = 8'd2; m1_arvalid = 1;
        step(); step();
        m1_arvalid = 0;
        do_beat(1'b1, 32'hB1, 1'b0, 2'b00);
        s_rvalid = 1; s_rdata = 32'hB2;
        #1;
        reset = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("t6_m1_rdata", m1_rdata, 32'h0);
        chk("t6_s_rready", 32'(s_rready), 32'd0);
        chk("t6_proto_err", 32'(proto_err), 32'd0);
        chk("t6_grant", 32'(grant_id), 32'd0);
        zero_inputs();
        step();
        reset = 1'b1;
        m1_araddr = 32'h0000_7200; m1_arlen = 8'd0; m1_arvalid = 1; s_arready = 1;
        #1;
        chk("t6_post_idle", 32'(busy), 32'd0);
        step(); #1;
        ar_check(1'b1, 32'h0000_7200, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
